// File: rtl/turn_scheduler.sv
// turn_scheduler: sequences one battle turn through the shared datapath.
// Player roll/issue/wait/check, then AI roll/issue/wait/check, then end.
module turn_scheduler #(
    parameter int         HP_W      = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            go,
    input  logic [1:0]      move_op,
    input  logic [HP_W-1:0] accu,
    input  logic [HP_W-1:0] ai_hp,
    input  logic            ai_dead,
    input  logic            p_dead,
    input  logic            dp_done,
    input  logic            rng_ld,
    input  logic [7:0]      rng_val,
    output logic            dp_start,
    output logic            active_trainer,
    output logic            target,
    output logic            apply_p_damage,
    output logic            apply_ai_damage,
    output logic            p_heal,
    output logic            catch,
    output logic            load_ai_hp,
    output logic            hit,
    output logic            busy,
    output logic            victory,
    output logic            loss,
    output logic            caught,
    output logic            timeout_err,
    output logic [7:0]      turn_count
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [1:0] OP_HEAL  = 2'b01;
    localparam logic [1:0] OP_CATCH = 2'b10;

    // cmd bits: [3] p damage, [2] ai damage, [1] heal, [0] catch
    localparam logic [3:0] CMD_PDMG  = 4'b1000;
    localparam logic [3:0] CMD_AIDMG = 4'b0100;
    localparam logic [3:0] CMD_HEAL  = 4'b0010;
    localparam logic [3:0] CMD_CATCH = 4'b0001;

    typedef enum logic [3:0] {
        S_INIT, S_IDLE,
        S_P_ROLL, S_P_ISSUE, S_P_WAIT, S_P_CHECK,
        S_AI_ROLL, S_AI_ISSUE, S_AI_WAIT, S_AI_CHECK,
        S_END, S_WIN, S_LOSS, S_CAUGHT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             lfsr_fb;
    logic             go_q;
    logic             edge_q, edge_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       cmd_q, cmd_d;
    logic             act_q, act_d;
    logic             tgt_q, tgt_d;
    logic             hit_q, hit_d;
    logic             load_q, load_d;
    logic             tmo_q, tmo_d;
    logic [7:0]       tc_q, tc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HP_W-1:0]  rng_w;
    logic             p_hit;
    logic             ai_hit;

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lfsr_d  = (rng_ld && rng_val != 8'd0) ? rng_val
                                                 : {lfsr_q[6:0], lfsr_fb};
    assign rng_w   = HP_W'(lfsr_q[3:0]);
    assign ai_hit  = |lfsr_q[3:2];

    // A go edge only counts while idle; edges in any other state are dropped.
    assign edge_d = go & ~go_q & (state_q == S_IDLE);

    // Player roll outcome for the selected action (no-op rolls as attack).
    always_comb begin
        p_hit = rng_w < accu;
        if (move_op == OP_HEAL) begin
            p_hit = 1'b1;
        end else if (move_op == OP_CATCH) begin
            p_hit = ai_hp < rng_w;
        end
    end

    // State, LFSR and all held outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            lfsr_q  <= LFSR_SEED;
            go_q    <= 1'b0;
            edge_q  <= 1'b0;
            op_q    <= 2'b00;
            cmd_q   <= 4'b0000;
            act_q   <= 1'b0;
            tgt_q   <= 1'b0;
            hit_q   <= 1'b0;
            load_q  <= 1'b0;
            tmo_q   <= 1'b0;
            tc_q    <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            go_q    <= go;
            edge_q  <= edge_d;
            op_q    <= op_d;
            cmd_q   <= cmd_d;
            act_q   <= act_d;
            tgt_q   <= tgt_d;
            hit_q   <= hit_d;
            load_q  <= load_d;
            tmo_q   <= tmo_d;
            tc_q    <= tc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and decoded outputs of the turn sequencer.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cmd_d    = cmd_q;
        act_d    = act_q;
        tgt_d    = tgt_q;
        hit_d    = hit_q;
        load_d   = 1'b0;
        tmo_d    = tmo_q;
        tc_d     = tc_q;
        cnt_d    = cnt_q;
        dp_start = 1'b0;
        busy     = 1'b0;
        victory  = 1'b0;
        loss     = 1'b0;
        caught   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                load_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (edge_q) begin
                    state_d = S_P_ROLL;
                end
            end
            S_P_ROLL: begin
                busy  = 1'b1;
                op_d  = move_op;
                hit_d = p_hit;
                if (move_op == OP_CATCH) begin
                    state_d = S_P_ISSUE;
                    cmd_d   = CMD_CATCH;
                    act_d   = 1'b0;
                    tgt_d   = 1'b1;
                end else if (p_hit) begin
                    state_d = S_P_ISSUE;
                    act_d   = 1'b0;
                    if (move_op == OP_HEAL) begin
                        cmd_d = CMD_HEAL;
                        tgt_d = 1'b0;
                    end else begin
                        cmd_d = CMD_AIDMG;
                        tgt_d = 1'b1;
                    end
                end else begin
                    state_d = S_AI_ROLL;
                end
            end
            S_P_ISSUE, S_AI_ISSUE: begin
                busy     = 1'b1;
                dp_start = 1'b1;
                cnt_d    = '0;
                state_d  = (state_q == S_P_ISSUE) ? S_P_WAIT : S_AI_WAIT;
            end
            S_P_WAIT, S_AI_WAIT: begin
                busy = 1'b1;
                if (dp_done) begin
                    cmd_d   = 4'b0000;
                    act_d   = 1'b0;
                    tgt_d   = 1'b0;
                    state_d = (state_q == S_P_WAIT) ? S_P_CHECK : S_AI_CHECK;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cmd_d   = 4'b0000;
                    act_d   = 1'b0;
                    tgt_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_P_CHECK: begin
                busy = 1'b1;
                if (op_q == OP_CATCH && hit_q) begin
                    state_d = S_CAUGHT;
                end else if (ai_dead) begin
                    state_d = S_WIN;
                end else begin
                    state_d = S_AI_ROLL;
                end
            end
            S_AI_ROLL: begin
                busy  = 1'b1;
                hit_d = ai_hit;
                if (ai_hit) begin
                    state_d = S_AI_ISSUE;
                    cmd_d   = CMD_PDMG;
                    act_d   = 1'b1;
                    tgt_d   = 1'b0;
                end else begin
                    state_d = S_END;
                end
            end
            S_AI_CHECK: begin
                busy    = 1'b1;
                state_d = p_dead ? S_LOSS : S_END;
            end
            S_END: begin
                tc_d    = (tc_q == 8'd255) ? tc_q : tc_q + 8'd1;
                state_d = S_IDLE;
            end
            S_WIN: begin
                victory = 1'b1;
            end
            S_LOSS: begin
                loss = 1'b1;
            end
            S_CAUGHT: begin
                caught = 1'b1;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign apply_p_damage  = cmd_q[3];
    assign apply_ai_damage = cmd_q[2];
    assign p_heal          = cmd_q[1];
    assign catch           = cmd_q[0];
    assign active_trainer  = act_q;
    assign target          = tgt_q;
    assign hit             = hit_q;
    assign load_ai_hp      = load_q;
    assign timeout_err     = tmo_q;
    assign turn_count      = tc_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: scripted turn-timeline model checked every cycle,
// with directed outcome cases, randomized turns and literal pins.
module tb_turn_scheduler;
    localparam int TO = 16;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       go      = 1'b0;
    logic [1:0] move_op = 2'b00;
    logic [3:0] accu    = 4'd0;
    logic [3:0] ai_hp   = 4'd0;
    logic       ai_dead = 1'b0;
    logic       p_dead  = 1'b0;
    logic       dp_done = 1'b0;
    logic       rng_ld  = 1'b0;
    logic [7:0] rng_val = 8'd0;

    logic       dp_start, active_trainer, target;
    logic       apply_p_damage, apply_ai_damage, p_heal, catch;
    logic       load_ai_hp, hit, busy;
    logic       victory, loss, caught, timeout_err;
    logic [7:0] turn_count;

    turn_scheduler #(
        .HP_W(4), .LFSR_SEED(8'hA5), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .move_op(move_op),
        .accu(accu), .ai_hp(ai_hp), .ai_dead(ai_dead), .p_dead(p_dead),
        .dp_done(dp_done), .rng_ld(rng_ld), .rng_val(rng_val),
        .dp_start(dp_start), .active_trainer(active_trainer),
        .target(target), .apply_p_damage(apply_p_damage),
        .apply_ai_damage(apply_ai_damage), .p_heal(p_heal),
        .catch(catch), .load_ai_hp(load_ai_hp), .hit(hit), .busy(busy),
        .victory(victory), .loss(loss), .caught(caught),
        .timeout_err(timeout_err), .turn_count(turn_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [7:0] m_lfsr;
    logic e_start, e_act, e_tgt, e_apd, e_aad, e_heal, e_catch;
    logic e_load, e_hit, e_busy, e_vic, e_loss, e_caught, e_tmo;
    logic [7:0] e_tc;

    task automatic chk1(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, a, e);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] a,
                        input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, a, e);
        end
    endtask

    // Reference random source: 8-bit Fibonacci LFSR, taps 8,6,5,4.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr = 8'hA5;
        else if (rng_ld && rng_val != 8'd0) m_lfsr = rng_val;
        else m_lfsr = {m_lfsr[6:0],
                       m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Single compare point, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("dp_start", dp_start, e_start);
            chk1("active_trainer", active_trainer, e_act);
            chk1("target", target, e_tgt);
            chk1("apply_p_damage", apply_p_damage, e_apd);
            chk1("apply_ai_damage", apply_ai_damage, e_aad);
            chk1("p_heal", p_heal, e_heal);
            chk1("catch", catch, e_catch);
            chk1("load_ai_hp", load_ai_hp, e_load);
            chk1("hit", hit, e_hit);
            chk1("busy", busy, e_busy);
            chk1("victory", victory, e_vic);
            chk1("loss", loss, e_loss);
            chk1("caught", caught, e_caught);
            chk1("timeout_err", timeout_err, e_tmo);
            chk8("turn_count", turn_count, e_tc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cmd();
        e_apd = 1'b0; e_aad = 1'b0; e_heal = 1'b0; e_catch = 1'b0;
        e_act = 1'b0; e_tgt = 1'b0;
    endtask

    task automatic clr_exp();
        clr_cmd();
        e_start = 1'b0; e_load = 1'b0; e_hit = 1'b0; e_busy = 1'b0;
        e_vic = 1'b0; e_loss = 1'b0; e_caught = 1'b0; e_tmo = 1'b0;
        e_tc = 8'd0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        #1;
        reset_n = 1'b0;
        go = 1'b0; dp_done = 1'b0; rng_ld = 1'b0; rng_val = 8'd0;
        ai_dead = 1'b0; p_dead = 1'b0;
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_dp_start", dp_start, 1'b0);
        chk1("rst_aad", apply_ai_damage, 1'b0);
        chk1("rst_load", load_ai_hp, 1'b0);
        chk1("rst_hit", hit, 1'b0);
        chk1("rst_tmo", timeout_err, 1'b0);
        chk1("rst_outcome", victory | loss | caught, 1'b0);
        chk8("rst_tc", turn_count, 8'd0);
        clr_exp();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();
        e_load = 1'b1;
        chk1("init_load", load_ai_hp, 1'b1);
        tick();
        e_load = 1'b0;
    endtask

    // Wait phase: enters in the issue cycle, leaves in the check cycle
    // (ok=1) or back in idle after a timeout (ok=0).
    task automatic wait_phase(input int d, input logic spur,
                              output logic ok);
        dp_done = spur;
        tick();
        dp_done = 1'b0;
        e_start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < TO; k++) begin
            dp_done = (k == d);
            tick();
            dp_done = 1'b0;
            if (k == d) begin
                clr_cmd();
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            clr_cmd();
            e_tmo  = 1'b1;
            e_busy = 1'b0;
        end
    endtask

    // One whole turn from idle, expectations derived from the turn rules.
    task automatic run_turn(input logic [1:0] op, input logic [3:0] acc,
                            input logic [3:0] hp, input logic aid,
                            input logic pd, input int dly_p,
                            input int dly_a, input logic [7:0] ld,
                            input logic spur);
        logic [3:0] r;
        logic       h;
        logic       ok;
        move_op = op; accu = acc; ai_hp = hp;
        ai_dead = aid; p_dead = pd;
        go = 1'b1;
        tick();
        go = 1'b0;
        if (ld != 8'd0) begin
            rng_ld = 1'b1;
            rng_val = ld;
        end
        tick();
        rng_ld = 1'b0;
        e_busy = 1'b1;
        r = m_lfsr[3:0];
        if (op == 2'b01) h = 1'b1;
        else if (op == 2'b10) h = (hp < r);
        else h = (r < acc);
        tick();
        e_hit = h;
        if (h || op == 2'b10) begin
            e_start = 1'b1;
            e_act   = 1'b0;
            if (op == 2'b01) begin
                e_heal = 1'b1; e_tgt = 1'b0;
            end else if (op == 2'b10) begin
                e_catch = 1'b1; e_tgt = 1'b1;
            end else begin
                e_aad = 1'b1; e_tgt = 1'b1;
            end
            wait_phase(dly_p, spur, ok);
            if (!ok) return;
            tick();
            if (op == 2'b10 && h) begin
                e_caught = 1'b1; e_busy = 1'b0;
                return;
            end
            if (aid) begin
                e_vic = 1'b1; e_busy = 1'b0;
                return;
            end
        end
        r = m_lfsr[3:0];
        h = (r[3:2] != 2'b00);
        tick();
        e_hit = h;
        if (h) begin
            e_start = 1'b1; e_act = 1'b1; e_tgt = 1'b0; e_apd = 1'b1;
            wait_phase(dly_a, spur, ok);
            if (!ok) return;
            tick();
            if (pd) begin
                e_loss = 1'b1; e_busy = 1'b0;
                return;
            end
        end
        e_busy = 1'b0;
        tick();
        e_tc = (e_tc == 8'd255) ? e_tc : e_tc + 8'd1;
    endtask

    initial begin
        logic [1:0] op;
        int         dp;
        int         da;
        logic [7:0] ld;
        clr_exp();
        do_reset();

        run_turn(2'b00, 4'd8, 4'd5, 1'b0, 1'b0, 2, 1, 8'h03, 1'b0);
        chk8("atk_hit_tc", turn_count, 8'd1);

        run_turn(2'b00, 4'd8, 4'd5, 1'b0, 1'b0, 0, 0, 8'h09, 1'b0);
        chk8("atk_miss_tc", turn_count, 8'd2);

        for (int v = 1; v <= 16; v++) begin
            ld = 8'(v);
            run_turn(2'b00, 4'd0, 4'd5, 1'b0, 1'b0, 0, 0, ld, 1'b0);
        end
        run_turn(2'b11, 4'd15, 4'd5, 1'b0, 1'b0, 3, 2, 8'h02, 1'b1);
        run_turn(2'b01, 4'd0, 4'd5, 1'b0, 1'b0, 15, 4, 8'h0F, 1'b1);
        run_turn(2'b10, 4'd0, 4'd9, 1'b0, 1'b0, 1, 1, 8'h05, 1'b0);
        chk1("catch_miss", caught, 1'b0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0: op = 2'b00;
                1: op = 2'b01;
                default: op = 2'b11;
            endcase
            dp = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 15);
            da = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 15);
            ld = $urandom_range(0, 1) ? 8'($urandom_range(1, 255)) : 8'd0;
            run_turn(op, 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 1'b0, 1'b0, dp, da, ld,
                     1'($urandom_range(0, 1)));
        end

        do_reset();
        for (int t = 0; t < 258; t++) begin
            run_turn(2'b00, 4'd0, 4'd5, 1'b0, 1'b0, 0, 0, 8'd0, 1'b0);
        end
        chk8("sat_tc", turn_count, 8'd255);

        do_reset();
        run_turn(2'b10, 4'd0, 4'd2, 1'b0, 1'b0, 3, 0, 8'h05, 1'b0);
        chk1("caught_lit", caught, 1'b1);
        chk1("caught_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            go = 1'b1;
            tick();
            go = 1'b0;
            tick();
            tick();
        end

        do_reset();
        run_turn(2'b00, 4'd8, 4'd5, 1'b1, 1'b0, 1, 0, 8'h03, 1'b0);
        chk1("victory_lit", victory, 1'b1);
        tick();
        tick();

        do_reset();
        run_turn(2'b00, 4'd2, 4'd5, 1'b0, 1'b1, 0, 0, 8'h0F, 1'b0);
        chk1("loss_lit", loss, 1'b1);
        tick();

        do_reset();
        run_turn(2'b00, 4'd8, 4'd5, 1'b0, 1'b0, 99, 0, 8'h03, 1'b0);
        chk1("tmo_lit", timeout_err, 1'b1);
        chk1("tmo_busy", busy, 1'b0);
        chk8("tmo_tc", turn_count, 8'd0);
        run_turn(2'b01, 4'd0, 4'd5, 1'b0, 1'b0, 2, 2, 8'd0, 1'b0);

        chk_en  = 1'b0;
        move_op = 2'b00; accu = 4'd8; ai_hp = 4'd5;
        go = 1'b1;
        tick();
        go = 1'b0;
        rng_ld = 1'b1; rng_val = 8'h03;
        tick();
        rng_ld = 1'b0;
        tick();
        chk1("mid_start", dp_start, 1'b1);
        tick();
        tick();
        chk1("mid_busy", busy, 1'b1);
        chk1("mid_aad", apply_ai_damage, 1'b1);
        do_reset();
        run_turn(2'b00, 4'd8, 4'd5, 1'b0, 1'b0, 0, 0, 8'h03, 1'b0);
        chk8("post_rst_tc", turn_count, 8'd1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
